// File: rtl/reset_ctrl_multi.sv
// reset_ctrl_multi: multi-source reset pulse generator.
// Each asynchronous request is synchronised and debounced in its own lane; a
// small FSM turns any new (masked-in) request into one synchronous reset pulse
// of at least PULSE_CYCLES clocks and records which sources caused it.
// Optional build macro: RESET_CTRL_RETRIGGER_EN -- new requests arriving while
// the pulse is counting reload the pulse counter.

// Per-source lane: synchroniser chain, symmetric debounce, rising-edge detect.
module reset_ctrl_multi_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic clock,
  input  logic async_res,
  input  logic src_i,
  output logic db_o,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   db_dly_q, db_dly_d;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the raw request in; count disagreeing samples and flip the level on the last one.
  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], src_i};
    cnt_d    = '0;
    db_d     = db_q;
    db_dly_d = db_q;
    if (s != db_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) db_d = s;
      else                                    cnt_d = cnt_q + CW'(1);
    end
  end

  // Lane state registers.
  always_ff @(posedge clock or posedge async_res) begin
    if (async_res) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      db_q     <= 1'b0;
      db_dly_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      db_dly_q <= db_dly_d;
    end
  end

  assign db_o   = db_q;
  assign rise_o = db_q & ~db_dly_q;
endmodule

// Top level: lanes plus the pulse FSM.
module reset_ctrl_multi #(
  parameter int NUM_SRC         = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter int PULSE_CYCLES    = 8000000
) (
  input  logic               clock,
  input  logic               async_res,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] src_mask,
  input  logic               cause_clr,
  output logic               res,
  output logic [NUM_SRC-1:0] res_cause,
  output logic               busy
);
  localparam int PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [PW-1:0] PLOAD = PW'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HOLD, WAIT_REL} state_e;

  logic [NUM_SRC-1:0] db, db_rise, rise;
  logic               req;

  state_e             state_q, state_d;
  logic [PW-1:0]      pcnt_q, pcnt_d;
  logic [NUM_SRC-1:0] cause_q, cause_d;
  logic               res_q, res_d;
  logic               busy_q, busy_d;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_lane
    reset_ctrl_multi_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clock    (clock),
      .async_res(async_res),
      .src_i    (src[i]),
      .db_o     (db[i]),
      .rise_o   (db_rise[i])
    );
  end

  // A held-but-masked source never produces a rise, even if unmasked later.
  assign rise = db_rise & src_mask;
  assign req  = |(db & src_mask);

  // Next-state, pulse counter and cause bookkeeping.
  always_comb begin
    state_d = state_q;
    pcnt_d  = pcnt_q;
    cause_d = cause_q;
    case (state_q)
      IDLE: begin
        if (|rise) begin
          cause_d = rise;
          pcnt_d  = PLOAD;
          state_d = HOLD;
        end else if (cause_clr) begin
          cause_d = '0;
        end
      end
      HOLD: begin
        cause_d = cause_q | rise;
`ifdef RESET_CTRL_RETRIGGER_EN
        if (|rise)                  pcnt_d  = PLOAD;
        else if (pcnt_q == '0)      state_d = req ? WAIT_REL : IDLE;
        else                        pcnt_d  = pcnt_q - PW'(1);
`else
        if (pcnt_q == '0)           state_d = req ? WAIT_REL : IDLE;
        else                        pcnt_d  = pcnt_q - PW'(1);
`endif
      end
      WAIT_REL: begin
        if (!req) state_d = IDLE;
      end
      default: begin
        state_d = HOLD;
        pcnt_d  = PLOAD;
      end
    endcase
    res_d  = (state_d != IDLE);
    busy_d = (state_d != IDLE);
  end

  // FSM and registered outputs; reset forces a fresh full pulse.
  always_ff @(posedge clock or posedge async_res) begin
    if (async_res) begin
      state_q <= HOLD;
      pcnt_q  <= PLOAD;
      cause_q <= '0;
      res_q   <= 1'b1;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      cause_q <= cause_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
    end
  end

  assign res       = res_q;
  assign busy      = busy_q;
  assign res_cause = cause_q;
endmodule
